// File: rtl/peripheral_mpram_wb_slave.sv
// Wishbone B3 slave front-end for a byte-write MPRAM with a 1-cycle registered read.
// Optional incrementing-burst support is built when MPRAM_WB_BURST_EN is defined.
module peripheral_mpram_wb_slave #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH),
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW+1:0] wb_adr_i,
   input  logic [DW-1:0] wb_dat_i,
   input  logic [3:0]    wb_sel_i,
   input  logic          wb_we_i,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   input  logic [2:0]    wb_cti_i,
   input  logic [1:0]    wb_bte_i,
   output logic [DW-1:0] wb_dat_o,
   output logic          wb_ack_o,
   output logic [3:0]    ram_we,
   output logic [DW-1:0] ram_din,
   output logic [AW-1:0] ram_waddr,
   output logic [AW-1:0] ram_raddr,
   input  logic [DW-1:0] ram_dout
);

   typedef enum logic {IDLE, BURST} state_t;

   state_t        state, state_nx;
   logic          ack_q, ack_nx;
   logic [AW-1:0] adr_q, adr_nx;
   logic          req;
   logic          burst_go;
   logic [AW-1:0] word_adr;
   logic [AW-1:0] adr_inc;

   assign req       = wb_cyc_i & wb_stb_i;
   assign word_adr  = wb_adr_i[AW+1:2];
   assign wb_ack_o  = ack_q & req & ~rst;
   assign ram_we    = (wb_ack_o & wb_we_i) ? wb_sel_i : 4'h0;
   assign ram_din   = wb_dat_i;
   assign ram_waddr = adr_q;
   assign wb_dat_o  = ram_dout;

`ifdef MPRAM_WB_BURST_EN
   // Linear bursts wrap at DEPTH; wrapped bursts only advance the low 2/3/4 bits.
   function automatic logic [AW-1:0] next_adr(input logic [AW-1:0] a, input logic [1:0] bte);
      logic [AW-1:0] mask;
      logic [AW-1:0] lin;
      lin = (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
      case (bte)
         2'b01:   mask = AW'(3);
         2'b10:   mask = AW'(7);
         2'b11:   mask = AW'(15);
         default: mask = '0;
      endcase
      if (bte == 2'b00) next_adr = lin;
      else              next_adr = (a & ~mask) | ((a + AW'(1)) & mask);
   endfunction

   logic [1:0] unused_bits;

   assign unused_bits = wb_adr_i[1:0];
   assign burst_go    = req & ack_q & (wb_cti_i == 3'b010);
   assign adr_inc     = next_adr(adr_q, wb_bte_i);
   // Prefetch the following beat so its data lands together with the next ack.
   assign ram_raddr   = (state == BURST || burst_go) ? adr_inc : word_adr;
`else
   logic [6:0] unused_bits;

   assign unused_bits = {wb_adr_i[1:0], wb_cti_i, wb_bte_i};
   assign burst_go    = 1'b0;
   assign adr_inc     = adr_q;
   assign ram_raddr   = word_adr;
`endif

   always_comb begin
      state_nx = state;
      ack_nx   = ack_q;
      adr_nx   = adr_q;
      case (state)
         IDLE: begin
            if (ack_q) begin
               if (burst_go) begin
                  state_nx = BURST;
                  adr_nx   = adr_inc;
               end else begin
                  ack_nx = 1'b0;
               end
            end else if (req) begin
               adr_nx = word_adr;
               ack_nx = 1'b1;
            end
         end
         BURST: begin
            // Any non-continuing beat or a dropped request ends the burst.
            if (burst_go) begin
               adr_nx = adr_inc;
            end else begin
               state_nx = IDLE;
               ack_nx   = 1'b0;
            end
         end
         default: begin
            state_nx = IDLE;
            ack_nx   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ack_q <= 1'b0;
         adr_q <= '0;
      end else begin
         state <= state_nx;
         ack_q <= ack_nx;
         adr_q <= adr_nx;
      end
   end

endmodule

// File: tb/tb_peripheral_mpram_wb_slave.sv
// Randomized scoreboard bench for peripheral_mpram_wb_slave with a behavioural RAM and reference memory.
// Expectations adapt to whether MPRAM_WB_BURST_EN is defined.
module tb_peripheral_mpram_wb_slave;

   localparam int DEPTH = 256;
   localparam int AW    = 8;
`ifdef MPRAM_WB_BURST_EN
   localparam bit BURST_ON = 1'b1;
`else
   localparam bit BURST_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [AW+1:0] wb_adr_i;
   logic [31:0]   wb_dat_i;
   logic [3:0]    wb_sel_i;
   logic          wb_we_i;
   logic          wb_cyc_i;
   logic          wb_stb_i;
   logic [2:0]    wb_cti_i;
   logic [1:0]    wb_bte_i;
   logic [31:0]   wb_dat_o;
   logic          wb_ack_o;
   logic [3:0]    ram_we;
   logic [31:0]   ram_din;
   logic [AW-1:0] ram_waddr;
   logic [AW-1:0] ram_raddr;
   logic [31:0]   ram_dout;

   always #5 clk = ~clk;

   peripheral_mpram_wb_slave #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
      .ram_we(ram_we), .ram_din(ram_din), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
      .ram_dout(ram_dout)
   );

   // Behavioural byte-write RAM with registered read, the device this front-end drives.
   logic [31:0] mem [DEPTH];
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (ram_we[b]) mem[ram_waddr][8*b +: 8] <= ram_din[8*b +: 8];
      ram_dout <= mem[ram_raddr];
   end

   typedef struct {
      bit            we;
      logic [AW-1:0] adr;
      logic [31:0]   data;
      logic [3:0]    sel;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] bdata [16];
   logic [31:0] last_read;
   int          checks = 0;
   int          errors = 0;

   // Every acked beat must match the oldest outstanding expectation; no write without ack.
   always @(negedge clk) begin
      if (wb_ack_o) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_ack at %0t: got ack with no pending beat, required none", $time);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.we) begin
               if (ram_we !== mon_e.sel || ram_waddr !== mon_e.adr) begin
                  errors++;
                  $display("[TB] FAIL write_beat: got we=%h addr=%h, required we=%h addr=%h",
                           ram_we, ram_waddr, mon_e.sel, mon_e.adr);
               end
            end else begin
               last_read = wb_dat_o;
               if (wb_dat_o !== mon_e.data) begin
                  errors++;
                  $display("[TB] FAIL read_beat addr=%h: got %h, required %h", mon_e.adr, wb_dat_o, mon_e.data);
               end
            end
         end
      end else begin
         checks++;
         if (ram_we !== 4'h0) begin
            errors++;
            $display("[TB] FAIL stray_write: got ram_we=%h without ack, required 0", ram_we);
         end
      end
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   function automatic int next_ref(input int a, input logic [1:0] bte);
      int size;
      size = (bte == 2'b01) ? 4 : (bte == 2'b10) ? 8 : 16;
      if (bte == 2'b00) return (a + 1) % DEPTH;
      return (a / size) * size + ((a % size) + 1) % size;
   endfunction

   task automatic release_bus();
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      wb_cti_i = 3'b000;
      wb_bte_i = 2'b00;
   endtask

   // Drive one beat and record what the DUT must do when it acks it.
   task automatic apply_stimulus(input bit we, input int a, input logic [31:0] d,
                                 input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte);
      exp_t e;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = we;
      wb_adr_i = {a[AW-1:0], 2'($urandom)};
      wb_dat_i = d;
      wb_sel_i = sel;
      wb_cti_i = cti;
      wb_bte_i = bte;
      e.we   = we;
      e.adr  = a[AW-1:0];
      e.sel  = sel;
      e.data = ref_mem[a];
      exp_q.push_back(e);
      if (we)
         for (int b = 0; b < 4; b++)
            if (sel[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
   endtask

   task automatic wait_ack(output int waits);
      waits = 0;
      while (1) begin
         @(negedge clk);
         if (wb_ack_o) break;
         waits++;
         if (waits > 16) begin
            checks++;
            errors++;
            $display("[TB] FAIL ack_timeout: got no ack in 16 cycles, required ack");
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic classic_beat(input bit we, input int a, input logic [31:0] d, input logic [3:0] sel);
      int w;
      @(posedge clk);
      #1;
      apply_stimulus(we, a, d, sel, 3'b000, 2'b00);
      wait_ack(w);
      check_output("classic_latency", w, 1);
      release_bus();
   endtask

   task automatic run_burst(input bit we, input int start, input int n, input logic [1:0] bte);
      int a;
      int w;
      a = start;
      @(posedge clk);
      #1;
      for (int k = 0; k < n; k++) begin
         apply_stimulus(we, a, bdata[k], 4'hF, (k == n - 1) ? 3'b111 : 3'b010, bte);
         wait_ack(w);
         check_output("burst_latency", w, (k == 0 || !BURST_ON) ? 1 : 0);
         a = next_ref(a, bte);
      end
      release_bus();
      @(negedge clk);
      check_output("ack_after_eob", wb_ack_o, 0);
   endtask

   task automatic reset_mid_burst(input int start);
      int w;
      bdata[0] = $urandom;
      bdata[1] = ~ref_mem[start + 1];
      @(posedge clk);
      #1;
      apply_stimulus(1'b1, start, bdata[0], 4'hF, 3'b010, 2'b00);
      wait_ack(w);
      wb_adr_i = {8'(start + 1), 2'b00};
      wb_dat_i = bdata[1];
      wb_cti_i = 3'b111;
      rst      = 1'b1;
      @(negedge clk);
      check_output("rst_ack", wb_ack_o, 0);
      check_output("rst_we", ram_we, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      release_bus();
      classic_beat(1'b0, start, 32'h0, 4'h0);
      classic_beat(1'b0, start + 1, 32'h0, 4'h0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got no finish, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int op;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
      last_read = '0;
      wb_adr_i  = '0;
      wb_dat_i  = '0;
      wb_sel_i  = 4'hF;
      release_bus();
      // A request held during reset must not be acked nor write.
      rst      = 1'b1;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_output("reset_ack", wb_ack_o, 0);
      end
      @(posedge clk);
      #1;
      release_bus();
      rst = 1'b0;

      classic_beat(1'b1, 5, 32'hDEADBEEF, 4'hF);
      classic_beat(1'b0, 5, 32'h0, 4'h0);
      check_output("read_deadbeef", last_read, 32'hDEADBEEF);
      classic_beat(1'b1, 5, 32'h0000AA00, 4'b0010);
      classic_beat(1'b0, 5, 32'h0, 4'h0);
      check_output("read_byte_merge", last_read, 32'hDEADAAEF);

      run_burst(1'b0, 'hFE, 4, 2'b00);

      for (int k = 0; k < 4; k++) bdata[k] = 32'(k + 1);
      run_burst(1'b1, 6, 4, 2'b01);
      classic_beat(1'b0, 6, 32'h0, 4'h0);
      check_output("wrap4_word6", last_read, 32'd1);
      classic_beat(1'b0, 7, 32'h0, 4'h0);
      check_output("wrap4_word7", last_read, 32'd2);
      classic_beat(1'b0, 4, 32'h0, 4'h0);
      check_output("wrap4_word4", last_read, 32'd3);
      classic_beat(1'b0, 5, 32'h0, 4'h0);
      check_output("wrap4_word5", last_read, 32'd4);

      reset_mid_burst('h40);

      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 2);
         if (op == 0) begin
            classic_beat(1'b1, $urandom_range(0, DEPTH - 1), $urandom, 4'($urandom));
         end else if (op == 1) begin
            classic_beat(1'b0, $urandom_range(0, DEPTH - 1), 32'h0, 4'h0);
         end else begin
            for (int k = 0; k < 16; k++) bdata[k] = $urandom;
            run_burst(1'($urandom), $urandom_range(0, DEPTH - 1), $urandom_range(1, 6), 2'($urandom));
         end
      end

      repeat (4) @(posedge clk);
      check_output("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
